// File: rtl/adc_dac_seq_ctrl.sv
// adc_dac_seq_ctrl: sequencing controller for the ADC->DAC datapath.
// Selects live pass-through, triggered capture into an on-chip buffer, or
// looped playback of that buffer to the DAC. All logic runs on clk.
module adc_dac_seq_ctrl #(
    parameter int                DATA_W   = 14,
    parameter int                ADDR_W   = 10,
    parameter logic [DATA_W-1:0] MIDSCALE = 14'h2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [DATA_W-1:0] trig_level,
    output logic [DATA_W-1:0] dac_data,
    output logic [2:0]        state,
    output logic              busy,
    output logic              capture_done,
    output logic              buf_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    localparam logic [1:0] OP_PASS = 2'd0;
    localparam logic [1:0] OP_ARM  = 2'd1;
    localparam logic [1:0] OP_PLAY = 2'd2;
    localparam logic [1:0] OP_STOP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_PLAY    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              buf_valid_q, buf_valid_d;
    logic              busy_q, cmd_ready_q;
    logic [DATA_W-1:0] dac_q;
    logic [DATA_W-1:0] dac_sel_s;
    logic              we_s;
    logic              capture_done_s;
    logic              trig_s;
    logic              cmd_acc_s;

    // Sample buffer; single port, writes only during ARMED/CAPTURE, reads only in PLAY.
    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state, datapath control and command handling.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        lvl_d          = lvl_q;
        prev_d         = prev_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        buf_valid_d    = buf_valid_q;
        we_s           = 1'b0;
        capture_done_s = 1'b0;
        dac_sel_s      = MIDSCALE;
        trig_s         = (prev_q < lvl_q) && (adc_data >= lvl_q);
        cmd_acc_s      = cmd_valid && cmd_ready_q;

        case (state_q)
            ST_IDLE: begin
                dac_sel_s = MIDSCALE;
            end
            ST_PASS: begin
                dac_sel_s = adc_data;
            end
            ST_ARMED: begin
                prev_d = adc_data;
                if (trig_s) begin
                    // Trigger sample goes to address 0 (wr_addr_q is 0 while armed).
                    we_s = 1'b1;
                    if (len_q == '0) begin
                        capture_done_s = 1'b1;
                        buf_valid_d    = 1'b1;
                        state_d        = ST_IDLE;
                    end else begin
                        wr_addr_d = ADDR_ONE;
                        state_d   = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                we_s = 1'b1;
                if (wr_addr_q == len_q) begin
                    // Last write: address stays at len so it never runs past it.
                    capture_done_s = 1'b1;
                    buf_valid_d    = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                end
            end
            ST_PLAY: begin
                if (rd_addr_q == len_q) begin
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commands are only accepted outside ARMED/CAPTURE, so they never
        // collide with the capture logic above.
        if (cmd_acc_s) begin
            case (cmd_op)
                OP_PASS: begin
                    state_d = ST_PASS;
                end
                OP_ARM: begin
                    state_d     = ST_ARMED;
                    len_d       = cfg_len;
                    lvl_d       = trig_level;
                    prev_d      = adc_data;
                    wr_addr_d   = '0;
                    buf_valid_d = 1'b0;
                end
                OP_PLAY: begin
                    if (buf_valid_q) begin
                        state_d   = ST_PLAY;
                        rd_addr_d = '0;
                    end else begin
                        state_d = state_q;
                    end
                end
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end else begin
            cmd_acc_s = 1'b0;
        end
    end

    // Control/state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            lvl_q       <= '0;
            prev_q      <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            buf_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            lvl_q       <= lvl_d;
            prev_q      <= prev_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            buf_valid_q <= buf_valid_d;
            busy_q      <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
            cmd_ready_q <= !((state_d == ST_ARMED) || (state_d == ST_CAPTURE));
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[wr_addr_q] <= adc_data;
        end
    end

    // DAC output register; in PLAY it is the synchronous RAM read register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_q <= MIDSCALE;
        end else if (state_q == ST_PLAY) begin
            dac_q <= mem[rd_addr_q];
        end else begin
            dac_q <= dac_sel_s;
        end
    end

    assign dac_data     = dac_q;
    assign state        = state_q;
    assign busy         = busy_q;
    assign cmd_ready    = cmd_ready_q;
    assign buf_valid    = buf_valid_q;
    assign capture_done = capture_done_s;

endmodule
